// File: rtl/xor_decrypt_rx.sv
// Receive side of the XOR cipher link: deserializes ciphertext,
// decrypts with the replicated key and queues plaintext in a FIFO.
module xor_decrypt_rx #(
  parameter int KEY_SIZE   = 4,
  parameter int MSG_SIZE   = 8,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                iClk,
  input  logic                iRst,
  input  logic                iEn,
  input  logic                iSerial_in,
  input  logic                iFrame,
  input  logic                iLoad_key,
  input  logic [KEY_SIZE-1:0] iKey,
  input  logic                iReady,
  output logic [MSG_SIZE-1:0] oPlain,
  output logic                oValid,
  output logic                oBusy,
  output logic                oOverflow
);

  localparam int CW  = $clog2(MSG_SIZE);
  localparam int PW  = $clog2(FIFO_DEPTH);
  localparam int REP = MSG_SIZE / KEY_SIZE;

  typedef enum logic {
    IDLE = 1'b0,
    RECV = 1'b1
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [CW-1:0]       cnt;
  logic [MSG_SIZE-1:0] shreg;
  logic [KEY_SIZE-1:0] key;
  logic [MSG_SIZE-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0]       rd_ptr;
  logic [PW-1:0]       wr_ptr;
  logic [PW:0]         count;
  logic                ovf;

  logic                accept;
  logic                last;
  logic                busy;
  logic                word_done;
  logic                full;
  logic                pop;
  logic                push;
  logic [MSG_SIZE-1:0] raw;
  logic [MSG_SIZE-1:0] akey;
  logic [MSG_SIZE-1:0] word;

  assign accept = iEn & iFrame;
  assign last   = (cnt == CW'(MSG_SIZE - 1));
  // Truncation drops the oldest bit, giving the MSB-first shift.
  assign raw    = MSG_SIZE'({shreg, iSerial_in});
  assign akey   = {REP{key}};
  assign word   = raw ^ akey;

  assign full   = (count == (PW+1)'(FIFO_DEPTH));
  assign oValid = (count != '0);
  assign pop    = oValid & iReady;
  assign push   = word_done & (~full | pop);

  always_ff @(posedge iClk) begin
    if (!iRst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (accept) state_nxt = RECV;
      RECV: if (accept && last) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy      = 1'b0;
    word_done = 1'b0;
    unique case (state)
      IDLE: ;
      RECV: begin
        busy      = 1'b1;
        word_done = accept & last;
      end
      default: ;
    endcase
  end

  assign oBusy = busy;

  always_ff @(posedge iClk) begin
    if (!iRst) begin
      cnt   <= '0;
      shreg <= '0;
      key   <= '0;
    end else if (iEn) begin
      if (iLoad_key && state == IDLE) key <= iKey;
      if (iFrame) begin
        shreg <= raw;
        cnt   <= last ? '0 : cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge iClk) begin
    if (!iRst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      ovf    <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= word;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop) count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
      if (word_done && full && !pop) ovf <= 1'b1;
    end
  end

  assign oPlain    = mem[rd_ptr];
  assign oOverflow = ovf;

endmodule

// File: tb/tb_xor_decrypt_rx.sv
// Scoreboard bench for xor_decrypt_rx: directed scenarios plus
// random traffic checked against a word-level reference model.
module tb_xor_decrypt_rx;

  localparam int DEPTH = 2;

  logic       iClk = 1'b0;
  logic       iRst;
  logic       iEn;
  logic       iSerial_in;
  logic       iFrame;
  logic       iLoad_key;
  logic [3:0] iKey;
  logic       iReady;
  logic [7:0] oPlain;
  logic       oValid;
  logic       oBusy;
  logic       oOverflow;

  always #5 iClk = ~iClk;

  xor_decrypt_rx #(
    .KEY_SIZE(4),
    .MSG_SIZE(8),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .iClk(iClk),
    .iRst(iRst),
    .iEn(iEn),
    .iSerial_in(iSerial_in),
    .iFrame(iFrame),
    .iLoad_key(iLoad_key),
    .iKey(iKey),
    .iReady(iReady),
    .oPlain(oPlain),
    .oValid(oValid),
    .oBusy(oBusy),
    .oOverflow(oOverflow)
  );

  int nvec = 0;
  int nerr = 0;
  bit chk_on = 0;

  logic [7:0] exp_q[$];
  int         mbits;
  int         mcnt;
  logic [7:0] mword;
  logic [3:0] mkey;
  bit         movf;

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               name, act, exp, $time);
    end
  endtask

  // Commit one clock edge of the reference model.
  task automatic tick();
    bit acc, pop, done, idle_now, ld;
    logic rst, b;
    logic [3:0] k;
    rst = iRst;
    acc = iEn && iFrame;
    b = iSerial_in;
    ld = iEn && iLoad_key;
    k = iKey;
    pop = (mcnt > 0) && iReady;
    idle_now = (mbits == 0);
    done = 0;
    @(posedge iClk);
    if (!rst) begin
      mbits = 0;
      mword = 0;
      mkey = 0;
      mcnt = 0;
      movf = 0;
      exp_q.delete();
    end else begin
      if (acc) begin
        mword = {mword[6:0], b};
        mbits++;
        if (mbits == 8) begin
          done = 1;
          mbits = 0;
        end
      end
      if (done) begin
        if (mcnt < DEPTH || pop) begin
          exp_q.push_back(mword ^ {mkey, mkey});
          if (!pop) mcnt++;
        end else begin
          movf = 1;
        end
      end else if (pop) begin
        mcnt--;
      end
      if (ld && idle_now) mkey = k;
    end
    #1;
  endtask

  always @(negedge iClk) begin
    if (chk_on) begin
      check("valid", 32'(oValid), 32'(mcnt > 0));
      check("busy", 32'(oBusy), 32'(mbits > 0));
      check("overflow", 32'(oOverflow), 32'(movf));
      if (oValid && iReady && iRst) begin
        if (exp_q.size() == 0) begin
          check("pop_empty_q", 32'(oPlain), 32'hFFFF_FFFF);
        end else begin
          check("plain", 32'(oPlain), 32'(exp_q.pop_front()));
        end
      end
    end
  end

  task automatic send_bit(input logic b);
    iFrame = 1'b1;
    iSerial_in = b;
    tick();
  endtask

  task automatic send_word(input logic [7:0] c);
    for (int i = 7; i >= 0; i--) send_bit(c[i]);
  endtask

  task automatic idle(input int n);
    iFrame = 1'b0;
    repeat (n) tick();
  endtask

  task automatic do_reset();
    iRst = 1'b0;
    iFrame = 1'b0;
    tick();
    iRst = 1'b1;
  endtask

  task automatic load_key(input logic [3:0] k);
    iFrame = 1'b0;
    iLoad_key = 1'b1;
    iKey = k;
    tick();
    iLoad_key = 1'b0;
  endtask

  initial begin
    logic [7:0] w;
    iRst = 1'b0;
    iEn = 1'b0;
    iSerial_in = 1'b0;
    iFrame = 1'b0;
    iLoad_key = 1'b0;
    iKey = 4'h0;
    iReady = 1'b0;
    mbits = 0;
    mcnt = 0;
    mword = 0;
    mkey = 0;
    movf = 0;

    do_reset();
    chk_on = 1;
    check("reset_plain", 32'(oPlain), 32'h0);
    check("reset_valid", 32'(oValid), 32'h0);

    // Basic decrypt: 3C ^ AA = 96
    iEn = 1'b1;
    iReady = 1'b1;
    load_key(4'hA);
    send_word(8'h3C);
    idle(3);

    // Overflow: third word dropped
    do_reset();
    load_key(4'h0);
    iReady = 1'b0;
    send_word(8'h11);
    send_word(8'h22);
    send_word(8'h33);
    idle(1);
    check("ovf_sticky", 32'(oOverflow), 32'h1);
    iReady = 1'b1;
    idle(4);
    check("ovf_held", 32'(oOverflow), 32'h1);

    // Push and pop on the same edge at full
    do_reset();
    iReady = 1'b0;
    send_word(8'h11);
    send_word(8'h22);
    w = 8'h33;
    for (int i = 7; i >= 1; i--) send_bit(w[i]);
    iReady = 1'b1;
    send_bit(w[0]);
    idle(4);

    // Pauses: F0 ^ 55 = A5
    do_reset();
    load_key(4'h5);
    w = 8'hF0;
    for (int i = 7; i >= 5; i--) send_bit(w[i]);
    idle(3);
    for (int i = 4; i >= 2; i--) send_bit(w[i]);
    iEn = 1'b0;
    iFrame = 1'b1;
    tick();
    tick();
    iEn = 1'b1;
    for (int i = 1; i >= 0; i--) send_bit(w[i]);
    idle(3);

    // Reset discards a partial word
    load_key(4'h9);
    for (int i = 0; i < 5; i++) send_bit(1'b1);
    do_reset();
    send_word(8'hC3);
    idle(3);

    // Mid-word key load is ignored: 5A ^ 33 = 69
    load_key(4'h3);
    w = 8'h5A;
    for (int i = 7; i >= 4; i--) send_bit(w[i]);
    iLoad_key = 1'b1;
    iKey = 4'hF;
    send_bit(w[3]);
    iLoad_key = 1'b0;
    for (int i = 2; i >= 0; i--) send_bit(w[i]);
    idle(3);

    // Round trip: sender encrypts 5A with key 6
    load_key(4'h6);
    send_word(8'h5A ^ 8'h66);
    idle(3);

    // Random traffic
    for (int n = 0; n < 600; n++) begin
      iEn = ($urandom % 8) != 0;
      iFrame = ($urandom % 4) != 0;
      iSerial_in = 1'($urandom);
      iReady = ($urandom % 3) != 0;
      iLoad_key = ($urandom % 6) == 0;
      iKey = 4'($urandom);
      iRst = ($urandom % 150) != 0;
      tick();
    end

    iRst = 1'b1;
    iEn = 1'b1;
    iLoad_key = 1'b0;
    iReady = 1'b1;
    idle(6);
    check("drained", 32'(exp_q.size()), 32'h0);

    chk_on = 0;
    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nerr);
    $finish;
  end

endmodule
